mem_port_arbiter: RTL and testbench

Shares one 32-bit, variable-latency memory port between the core's instruction-fetch path and its half-word data path (LH/SH). It serialises the two requesters with round-robin arbitration, formats half-word lanes, and sign-extends loads. A timeout counter returns an error instead of hanging the core. It sits between the core's fetch/load-store logic and the single unified memory.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_lane_fmt.sv | 21 ++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter: FSM encoding,
// byte-enable patterns, timeout defaults and the half-word sign-extension helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;

    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W       = 8;

    // Sign-extend a loaded half-word to a full register word.
    function automatic logic [31:0] sext_half(input logic signed [15:0] half);
        logic signed [31:0] wide;
        wide = half;
        return wide;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Half-word lane formatting: byte enables, store replication and load extraction.
module mem_lane_fmt
    import mem_port_arbiter_pkg::*;
(
    input  logic        hi_lane,
    input  logic [15:0] half,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load
);

    // Select the active lane from address bit 1; the store half-word is
    // replicated so the memory picks the right half through the enables.
    always_comb begin
        be        = hi_lane ? BE_HI : BE_LO;
        wdata_rep = {half, half};
        load      = sext_half(hi_lane ? word[31:16] : word[15:0]);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency 32-bit memory port between
// instruction fetch and the half-word load/store path, with a timeout so a
// silent memory returns an error instead of stalling the core.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    state_t            state;
    state_t            state_n;

    logic              owner_d;
    logic              last_d;
    logic [31:0]       addr_q;
    logic              we_q;
    logic [15:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;

    logic              take;
    logic              grant_d;
    logic              misalign;
    logic              timeout_hit;
    logic              in_access;

    logic [3:0]        fmt_be;
    logic [31:0]       fmt_wdata;
    logic [31:0]       fmt_load;

    // Byte 0 of the latched address never matters: fetches are word accesses
    // and a misaligned half-word is rejected before it is latched for use.
    logic              unused_addr_bit;
    assign unused_addr_bit = addr_q[0];

    assign timeout_hit = (cnt_q == TO_LIM);
    assign in_access   = (state == ST_ACCESS);

    mem_lane_fmt u_lane_fmt (
        .hi_lane   (addr_q[1]),
        .half      (wdata_q),
        .word      (mem_rdata),
        .be        (fmt_be),
        .wdata_rep (fmt_wdata),
        .load      (fmt_load)
    );

    // State register; an asynchronous reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and round-robin grant; requests are only looked at in IDLE.
    always_comb begin
        state_n  = state;
        take     = 1'b0;
        grant_d  = 1'b0;
        misalign = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    take     = 1'b1;
                    grant_d  = d_req && (!i_req || !last_d);
                    misalign = grant_d && d_addr[0];
                    state_n  = misalign ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack || timeout_hit) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Latch the granted request, count ACCESS wait cycles, capture the
    // response and remember who was served for the next tie-break.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d   <= 1'b0;
            last_d    <= 1'b1;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        owner_d <= grant_d;
                        addr_q  <= grant_d ? d_addr : i_addr;
                        we_q    <= grant_d && d_we;
                        if (grant_d) begin
                            wdata_q <= d_wdata;
                        end
                        cnt_q   <= '0;
                        err_q   <= misalign;
                        if (misalign) begin
                            d_rdata_q <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        err_q <= 1'b0;
                        if (owner_d) begin
                            d_rdata_q <= we_q ? 32'd0 : fmt_load;
                        end else begin
                            i_rdata_q <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (owner_d) begin
                            d_rdata_q <= '0;
                        end else begin
                            i_rdata_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    last_d <= owner_d;
                end
                default: begin
                end
            endcase
        end
    end

    // Port and handshake outputs, decoded purely from registered state.
    always_comb begin
        mem_req = in_access;
        mem_we  = in_access && we_q;
        mem_be  = in_access ? (owner_d ? fmt_be : BE_WORD) : 4'b0000;
        i_ack   = (state == ST_RESP) && !owner_d;
        d_ack   = (state == ST_RESP) && owner_d;
        i_err   = i_ack && err_q;
        d_err   = d_ack && err_q;
    end

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = fmt_wdata;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester agents, a latency-programmable
// memory responder, and a transaction-schedule model checked every cycle.
module tb_mem_port_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    mem_port_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;          // mem_ack in ACCESS cycle lat; 0 = never
    logic [31:0] mem_word = '0;
    logic [3:0]  seen_be = '0;
    logic        seen_we = 1'b0;
    logic [31:0] seen_wd = '0;
    int          req_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory: acks in the lat-th consecutive mem_req cycle, records port fields.
    initial begin : responder
        int j;
        j = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                j++;
                seen_be = mem_be;
                seen_we = mem_we;
                seen_wd = mem_wdata;
                req_cycles++;
            end else begin
                j = 0;
            end
            mem_ack   = mem_req && (lat != 0) && (j == lat);
            mem_rdata = mem_ack ? mem_word : (32'h5A5A_0000 | 32'(j));
        end
    end

    // Model: each grant is a transaction with an absolute grant cycle g and
    // ack cycle a; mem_req spans g+1..a-1, the arbiter is free again at a+1.
    initial begin : model
        logic        busy, last_d_m, own_d, m_we, m_mis, m_err;
        logic        in_acc, e_iack, e_dack;
        logic [31:0] m_addr, m_word, e_rd;
        logic [15:0] m_wd, lane;
        logic [3:0]  e_be;
        int          g, a;
        busy = 1'b0; last_d_m = 1'b1; own_d = 1'b0; m_we = 1'b0; m_mis = 1'b0;
        m_err = 1'b0; m_addr = '0; m_word = '0; m_wd = '0; g = 0; a = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                busy = 1'b0;
                last_d_m = 1'b1;
            end else if (busy) begin
                if (cyc == a) begin
                    busy = 1'b0;
                    last_d_m = own_d;
                end
            end else if (i_req || d_req) begin
                own_d  = d_req && (!i_req || !last_d_m);
                m_addr = own_d ? d_addr : i_addr;
                m_we   = own_d && d_we;
                m_wd   = d_wdata;
                m_word = mem_word;
                m_mis  = own_d && d_addr[0];
                g      = cyc;
                busy   = 1'b1;
                if (m_mis) begin
                    a = g + 1; m_err = 1'b1;
                end else if (lat == 0 || lat > T + 1) begin
                    a = g + T + 2; m_err = 1'b1;
                end else begin
                    a = g + lat + 1; m_err = 1'b0;
                end
            end
            cyc++;
            #1;
            if (rst) begin
                chk("rst_i_ack", 32'(i_ack), 0);
                chk("rst_d_ack", 32'(d_ack), 0);
                chk("rst_mem_req", 32'(mem_req), 0);
                chk("rst_mem_we", 32'(mem_we), 0);
                chk("rst_mem_be", 32'(mem_be), 0);
                chk("rst_errs", {30'd0, i_err, d_err}, 0);
                chk("rst_i_rdata", i_rdata, 0);
                chk("rst_d_rdata", d_rdata, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
            end else begin
                in_acc = busy && !m_mis && (cyc > g) && (cyc < a);
                e_iack = busy && (cyc == a) && !own_d;
                e_dack = busy && (cyc == a) && own_d;
                e_be   = !in_acc ? 4'b0000 : (!own_d ? 4'b1111 : (m_addr[1] ? 4'b1100 : 4'b0011));
                chk("i_ack", 32'(i_ack), 32'(e_iack));
                chk("d_ack", 32'(d_ack), 32'(e_dack));
                chk("mem_req", 32'(mem_req), 32'(in_acc));
                chk("mem_we", 32'(mem_we), 32'(in_acc && m_we));
                chk("mem_be", 32'(mem_be), 32'(e_be));
                if (in_acc) chk("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
                if (in_acc && m_we) chk("mem_wdata", mem_wdata, {m_wd, m_wd});
                if (e_iack) begin
                    chk("i_rdata", i_rdata, m_err ? 32'd0 : m_word);
                    chk("i_err", 32'(i_err), 32'(m_err));
                end
                if (e_dack) begin
                    lane = m_addr[1] ? m_word[31:16] : m_word[15:0];
                    e_rd = (m_err || m_we) ? 32'd0 : {{16{lane[15]}}, lane};
                    chk("d_rdata", d_rdata, e_rd);
                    chk("d_err", 32'(d_err), 32'(m_err));
                end
            end
        end
    end

    task automatic fetch_txn(input logic [31:0] ad, output int lat_c,
                             output logic [31:0] rd, output logic er);
        int c0, t;
        @(negedge clk);
        i_addr = ad; i_req = 1'b1; c0 = cyc; t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (!i_ack && t < 40);
        chk("fetch_ack_seen", 32'(i_ack), 1);
        lat_c = cyc - c0; rd = i_rdata; er = i_err;
        @(negedge clk);
        i_req = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [31:0] ad, input logic [15:0] wd,
                            output int lat_c, output logic [31:0] rd, output logic er);
        int c0, t;
        @(negedge clk);
        d_we = we; d_addr = ad; d_wdata = wd; d_req = 1'b1; c0 = cyc; t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (!d_ack && t < 40);
        chk("data_ack_seen", 32'(d_ack), 1);
        lat_c = cyc - c0; rd = d_rdata; er = d_err;
        @(negedge clk);
        d_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int l1, l2, rc;
        logic [31:0] r1, r2;
        logic e1, e2;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Plain fetch, memory acks in the first ACCESS cycle.
        lat = 1; mem_word = 32'h00A0_0093;
        fetch_txn(32'h0000_0104, l1, r1, e1);
        chk("fetch_lat", 32'(l1), 2);
        chk("fetch_rdata", r1, 32'h00A0_0093);
        chk("fetch_err", 32'(e1), 0);
        chk("fetch_be", 32'(seen_be), 32'hF);

        // LH upper lane, negative half-word.
        lat = 2; mem_word = 32'h8001_1234;
        data_txn(1'b0, 32'h0000_0202, 16'h0000, l1, r1, e1);
        chk("lh_hi_lat", 32'(l1), 3);
        chk("lh_hi_rdata", r1, 32'hFFFF_8001);
        chk("lh_hi_be", 32'(seen_be), 32'hC);
        chk("lh_hi_we", 32'(seen_we), 0);

        // LH lower lane, positive half-word.
        data_txn(1'b0, 32'h0000_0200, 16'h0000, l1, r1, e1);
        chk("lh_lo_rdata", r1, 32'h0000_1234);
        chk("lh_lo_be", 32'(seen_be), 32'h3);

        // SH upper lane.
        lat = 1;
        data_txn(1'b1, 32'h0000_0206, 16'hBEEF, l1, r1, e1);
        chk("sh_lat", 32'(l1), 2);
        chk("sh_we", 32'(seen_we), 1);
        chk("sh_be", 32'(seen_be), 32'hC);
        chk("sh_wdata", seen_wd, 32'hBEEF_BEEF);
        chk("sh_rdata", r1, 0);

        // Misaligned LH: immediate error, memory untouched.
        rc = req_cycles;
        data_txn(1'b0, 32'h0000_0201, 16'h0000, l1, r1, e1);
        chk("mis_lat", 32'(l1), 1);
        chk("mis_err", 32'(e1), 1);
        chk("mis_rdata", r1, 0);
        chk("mis_no_req", 32'(req_cycles - rc), 0);

        // Silent memory: fetch times out.
        lat = 0; mem_word = 32'h1357_9BDF;
        fetch_txn(32'h0000_0300, l1, r1, e1);
        chk("to_lat", 32'(l1), 6);
        chk("to_err", 32'(e1), 1);
        chk("to_rdata", r1, 0);

        // Ack arriving in the last allowed cycle beats the timeout.
        lat = T + 1;
        fetch_txn(32'h0000_0308, l1, r1, e1);
        chk("edge_lat", 32'(l1), 6);
        chk("edge_err", 32'(e1), 0);
        chk("edge_rdata", r1, 32'h1357_9BDF);

        // Tie after a fetch: data goes first.
        lat = 1; mem_word = 32'h0000_7FFF;
        fork
            fetch_txn(32'h0000_0400, l1, r1, e1);
            data_txn(1'b0, 32'h0000_0500, 16'h0000, l2, r2, e2);
        join
        chk("rr_data_lat", 32'(l2), 2);
        chk("rr_fetch_lat", 32'(l1), 5);
        chk("rr_data_rdata", r2, 32'h0000_7FFF);

        // Tie right after reset: fetch first, accesses three cycles apart.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        rc = req_cycles;
        fork
            fetch_txn(32'h0000_0600, l1, r1, e1);
            data_txn(1'b0, 32'h0000_0702, 16'h0000, l2, r2, e2);
        join
        chk("rst_tie_fetch_lat", 32'(l1), 2);
        chk("rst_tie_data_lat", 32'(l2), 5);
        chk("rst_tie_req_cycles", 32'(req_cycles - rc), 2);

        // Reset in the middle of an access, then pending requests re-served.
        lat = 3; mem_word = 32'hCAFE_F00D;
        fork
            fetch_txn(32'h0000_0800, l1, r1, e1);
            data_txn(1'b1, 32'h0000_0900, 16'h1111, l2, r2, e2);
            begin
                @(negedge clk);
                @(posedge clk); @(posedge clk); #3;
                chk("mid_req_before", 32'(mem_req), 1);
                rst = 1'b1;
                #1;
                chk("mid_req_dropped", 32'(mem_req), 0);
                @(negedge clk); @(negedge clk);
                rst = 1'b0;
            end
        join
        chk("mid_fetch_lat", 32'(l1), 7);
        chk("mid_data_lat", 32'(l2), 12);
        chk("mid_fetch_rdata", r1, 32'hCAFE_F00D);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
